inst_buffer: RTL and testbench
==============================

Name: inst_buffer

Overview:
- Circular FIFO between fetch/decode and dispatch. Holds decoded DP packets and presents the oldest one to the ROB/RS dispatch interface.
- Dispatch pops an entry only when the ROB and RS both accept it (dp_ready).
- A branch misprediction flushes the whole buffer in one cycle.

Parameters:
IB_DEPTH, 8, number of entries; power of two, at least 2
PKT_W, 128, packet width; instantiated with $bits(DP_PACKET)

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-low reset
if_valid  in  1  upstream offers if_packet this cycle
if_packet  in  PKT_W  decoded instruction packet (DP_PACKET)
if_ready  out  1  buffer accepts if_packet this cycle
dp_ready  in  1  dispatch consumes ib_packet this cycle (rob_dp_available AND RS free)
ib_valid  out  1  ib_packet holds a valid oldest entry
ib_packet  out  PKT_W  oldest entry; all-zero when ib_valid=0
squash  in  1  branch mispredict; flush everything
ib_count  out  $clog2(IB_DEPTH)+1  occupied entries
ib_full  out  1  ib_count == IB_DEPTH
ib_empty  out  1  ib_count == 0

Behaviour:
- Storage: mem[0..IB_DEPTH-1]. Registers: head, tail ($clog2(IB_DEPTH) bits, wrap naturally modulo IB_DEPTH) and count.
- Reset (reset==0 at posedge):
  - head=tail=count=0; all mem entries zeroed.
  - Outputs after reset: if_ready=1, ib_valid=0, ib_packet=0, ib_count=0, ib_empty=1, ib_full=0.
  - Reset has priority over every other input, including mid-burst and mid-squash.
- Combinational outputs:
  - if_ready = !ib_full && !squash. It does not depend on dp_ready, so a full buffer refuses input even while it pops.
  - ib_valid = !ib_empty && !squash.
  - ib_packet = mem[head] when ib_valid, else 0.
- Enqueue (enq = if_valid && if_ready): at posedge, mem[tail] <= if_packet and tail <= tail+1.
- Dequeue (deq = ib_valid && dp_ready): at posedge, mem[head] <= 0 and head <= head+1.
- Count update:
  - enq && deq: count unchanged.
  - enq only: count +1.
  - deq only: count -1.
  - Count never exceeds IB_DEPTH or goes below 0 by construction.
- Latency: a packet enqueued at edge N is visible on ib_packet in cycle N+1 at the earliest. There is no same-cycle pass-through in base config.
- Squash (squash==1, reset==1):
  - At posedge: head=tail=count=0 and all entries zeroed.
  - Any enqueue or dequeue in that cycle is suppressed, because if_ready and ib_valid are forced low.
  - Buffer is empty and accepting input on the next cycle.
- Boundary cases:
  - Full with dp_ready=1: pops one entry; count drops to IB_DEPTH-1; if_ready is 1 next cycle.
  - Empty with if_valid=1: entry is written; ib_valid=1 next cycle.
  - Wrap-around is transparent; FIFO order is preserved across the wrap.
- Packet contents are opaque. The buffer never inspects or modifies DP_PACKET fields.

Optional Feature:
- Macro: IB_BYPASS_EN.
- When defined and the buffer is empty:
  - ib_valid = if_valid && !squash and ib_packet = if_packet, combinationally.
  - If dp_ready=1, the packet is consumed without being written; pointers and count are unchanged.
  - If dp_ready=0, the packet is enqueued normally.
  - When not empty, behaviour is identical to the base config.
- When undefined: 1-cycle minimum latency exactly as described in Behaviour.

Test Plan:
- Fill: reset, then drive if_valid=1 with packets 1..9 and dp_ready=0.
  - Required: entries 1..8 accepted; ib_full=1; if_ready=0 when offering packet 9; ib_count=8.
- Drain order: from full, dp_ready=1 for 8 cycles.
  - Required: ib_packet sequence 1..8; then ib_valid=0, ib_packet=0, ib_empty=1.
- Simultaneous enq/deq: count=4, if_valid=1 and dp_ready=1 for 20 cycles.
  - Required: ib_count stays 4; outputs are strictly in order; pointers wrap multiple times without loss.
- Full plus pop: count=8, if_valid=1, dp_ready=1.
  - Required: no enqueue that cycle; count becomes 7; the next cycle enqueues.
- Squash: count=5, assert squash together with if_valid=1 and dp_ready=1.
  - Required: if_ready=0 and ib_valid=0 that cycle; next cycle count=0 and ib_empty=1; a new packet A enqueued after squash appears as ib_packet=A.
- Reset mid-operation: count=6, drive reset=0 for one cycle with if_valid=1.
  - Required: count=0, ib_valid=0, ib_packet=0; the packet offered during reset is not stored.
  - With IB_BYPASS_EN, additionally check: empty buffer, if_valid=1, dp_ready=1 gives ib_packet=if_packet in the same cycle and count stays 0.

Source files
------------

// File: rtl/inst_buffer.sv
// inst_buffer: circular FIFO of decoded DP packets between decode and dispatch.
// The oldest entry is presented to dispatch. A squash flushes the whole buffer in one cycle.
// Optional macro IB_BYPASS_EN: when the buffer is empty, an incoming packet is shown
// to dispatch in the same cycle. If dispatch takes it, the packet is never written.
module inst_buffer #(
  parameter int IB_DEPTH = 8,
  parameter int PKT_W    = 128
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       if_valid,
  input  logic [PKT_W-1:0]           if_packet,
  output logic                       if_ready,
  input  logic                       dp_ready,
  output logic                       ib_valid,
  output logic [PKT_W-1:0]           ib_packet,
  input  logic                       squash,
  output logic [$clog2(IB_DEPTH):0]  ib_count,
  output logic                       ib_full,
  output logic                       ib_empty
);

  localparam int PTR_W = $clog2(IB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PKT_W-1:0] r_mem [IB_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_enq;
  logic             w_deq;
  logic             w_byp;

  assign ib_count = r_count;
  assign ib_full  = (r_count == CNT_W'(IB_DEPTH));
  assign ib_empty = (r_count == '0);

  // Handshake decode: what is offered to dispatch, and which pointer moves this cycle
  always_comb begin
    if_ready  = !ib_full && !squash;
    ib_valid  = !ib_empty && !squash;
    ib_packet = ib_valid ? r_mem[r_head] : '0;
    w_byp     = 1'b0;
`ifdef IB_BYPASS_EN
    if (ib_empty && if_valid && !squash) begin
      ib_valid  = 1'b1;
      ib_packet = if_packet;
      w_byp     = dp_ready;
    end
`endif
    // Stored-entry pop only; a bypassed packet never touches storage
    w_deq = !ib_empty && !squash && dp_ready;
    w_enq = if_valid && if_ready && !w_byp;
  end

  // Pointer, count and storage update; reset beats squash, squash beats traffic
  always_ff @(posedge clock) begin
    if (!reset || squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < IB_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_mem[r_tail] <= if_packet;
        r_tail        <= r_tail + PTR_W'(1);
      end
      // head and tail only coincide when empty or full, so enq and deq never hit one slot
      if (w_deq) begin
        r_mem[r_head] <= '0;
        r_head        <= r_head + PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed and random stimulus for inst_buffer, checked against a queue model.
module tb_inst_buffer;

  localparam int D  = 8;
  localparam int W  = 128;
  localparam int CW = $clog2(D) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          if_valid = 1'b0;
  logic [W-1:0]  if_packet = '0;
  logic          if_ready;
  logic          dp_ready = 1'b0;
  logic          ib_valid;
  logic [W-1:0]  ib_packet;
  logic          squash = 1'b0;
  logic [CW-1:0] ib_count;
  logic          ib_full;
  logic          ib_empty;

  int ncmp = 0;
  int nfail = 0;
  logic [W-1:0] q[$];

  inst_buffer #(.IB_DEPTH(D), .PKT_W(W)) dut (
    .clock(clock), .reset(reset), .if_valid(if_valid), .if_packet(if_packet),
    .if_ready(if_ready), .dp_ready(dp_ready), .ib_valid(ib_valid), .ib_packet(ib_packet),
    .squash(squash), .ib_count(ib_count), .ib_full(ib_full), .ib_empty(ib_empty)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] rnd_pkt();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs against the queue model, clock, update model.
  task automatic step(input logic v, input logic [W-1:0] p, input logic dr,
                      input logic sq, input logic rstn);
    logic         empty, e_ready, e_valid, byp, enq, deq;
    logic [W-1:0] e_pkt;
    if_valid  = v;
    if_packet = p;
    dp_ready  = dr;
    squash    = sq;
    reset     = rstn;
    #1;
    empty   = (q.size() == 0);
    e_ready = (q.size() < D) && !sq;
    e_valid = !empty && !sq;
    e_pkt   = e_valid ? q[0] : '0;
    byp     = 1'b0;
`ifdef IB_BYPASS_EN
    if (empty && v && !sq) begin
      e_valid = 1'b1;
      e_pkt   = p;
      byp     = dr;
    end
`endif
    chk("if_ready",  W'(if_ready),  W'(e_ready));
    chk("ib_valid",  W'(ib_valid),  W'(e_valid));
    chk("ib_packet", ib_packet,     e_pkt);
    chk("ib_count",  W'(ib_count),  W'(q.size()));
    chk("ib_full",   W'(ib_full),   W'(q.size() == D));
    chk("ib_empty",  W'(ib_empty),  W'(empty));
    @(posedge clock);
    #1;
    if (!rstn || sq) begin
      q.delete();
    end else begin
      deq = !empty && dr;
      enq = v && e_ready && !byp;
      if (deq) void'(q.pop_front());
      if (enq) q.push_back(p);
    end
  endtask

  initial begin
    logic [W-1:0] a;
    // Raw reset edge before any checks: state is unknown until the first clock
    reset = 1'b0;
    @(posedge clock);
    #1;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Fill with packets 1..9; the ninth must be refused
    for (int i = 1; i <= 9; i++) step(1'b1, W'(i), 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Drain: expect packets 1..8 in order, then empty
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Simultaneous enq/deq at count 4 across several wraps
    for (int i = 0; i < 4; i++) step(1'b1, rnd_pkt(), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, rnd_pkt(), 1'b1, 1'b0, 1'b1);

    // Full plus pop: no enqueue that cycle, enqueue on the next
    for (int i = 0; i < 4; i++) step(1'b1, rnd_pkt(), 1'b0, 1'b0, 1'b1);
    step(1'b1, rnd_pkt(), 1'b1, 1'b0, 1'b1);
    step(1'b1, rnd_pkt(), 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Squash at count 5 with traffic offered, then packet A
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, rnd_pkt(), 1'b0, 1'b0, 1'b1);
    step(1'b1, rnd_pkt(), 1'b1, 1'b1, 1'b1);
    a = rnd_pkt();
    step(1'b1, a, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("pkt_A", ib_packet, a);

    // Reset mid-operation at count 6 with a packet offered
    for (int i = 0; i < 5; i++) step(1'b1, rnd_pkt(), 1'b0, 1'b0, 1'b1);
    step(1'b1, rnd_pkt(), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Empty buffer, offer and consume in the same cycle
    a = rnd_pkt();
    step(1'b1, a, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Random traffic with occasional squash and reset
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), rnd_pkt(), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 49) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
